dot_vec_streamer: RTL and testbench

Transmitter-side companion to the pipelined 4-term dot-product unit. It holds up to DEPTH packed operand vectors in a small register file and, on a start pulse, issues them back-to-back, one per clock, as eight 4-bit operands. It tracks pipeline latency with a valid/tag shift register and captures each returning 10-bit result with its vector index. It replaces hand-written bench stimulus loops and sits between a host/loader and dot_product_pipelined.

---
 rtl/dot_vec_pkg.sv | 41 ++++
 rtl/dot_vec_tracker.sv | 37 +++
 rtl/dot_vec_streamer.sv | 145 ++++++++++++++
 tb/tb_dot_vec_streamer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_vec_pkg.sv
// Shared types and helpers for the dot-product vector streamer.
// Holds the FSM state encoding, operand/result widths and the vector unpacker.
package dot_vec_pkg;

  localparam int OPW  = 4;
  localparam int RESW = 10;
  localparam int VECW = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic [OPW-1:0] c;
    logic [OPW-1:0] d;
    logic [OPW-1:0] e;
    logic [OPW-1:0] f;
    logic [OPW-1:0] g;
    logic [OPW-1:0] h;
  } vec_ops_t;

  // Operand a sits in the most significant nibble, h in the least.
  function automatic vec_ops_t unpack_vec(input logic [VECW-1:0] w);
    vec_ops_t v;
    v.a = w[7*OPW +: OPW];
    v.b = w[6*OPW +: OPW];
    v.c = w[5*OPW +: OPW];
    v.d = w[4*OPW +: OPW];
    v.e = w[3*OPW +: OPW];
    v.f = w[2*OPW +: OPW];
    v.g = w[1*OPW +: OPW];
    v.h = w[0*OPW +: OPW];
    return v;
  endfunction

endpackage

// File: rtl/dot_vec_tracker.sv
// LAT-deep valid+tag shift register that follows issued items through a
// fixed-latency pipeline; the tail marks when a result is due.
module dot_vec_tracker #(
  parameter int LAT = 2,
  parameter int IW  = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_vld,
  input  logic [IW-1:0] i_idx,
  output logic          o_tail_vld,
  output logic [IW-1:0] o_tail_idx,
  output logic          o_empty
);

  logic [LAT-1:0] vld_q;
  logic [IW-1:0]  idx_q [LAT];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= i_vld;
      idx_q[0] <= i_idx;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign o_tail_vld = vld_q[LAT-1];
  assign o_tail_idx = idx_q[LAT-1];
  assign o_empty    = ~|vld_q;

endmodule

// File: rtl/dot_vec_streamer.sv
// Streams up to DEPTH stored operand vectors into a pipelined dot-product
// unit, one per clock, and collects each returning result with its slot index.
module dot_vec_streamer
  import dot_vec_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int LAT   = 2,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_wr_en,
  input  logic [IW-1:0]   i_wr_addr,
  input  logic [VECW-1:0] i_wr_data,
  input  logic            i_start,
  input  logic [IW:0]     i_num,
  output logic [OPW-1:0]  o_a,
  output logic [OPW-1:0]  o_b,
  output logic [OPW-1:0]  o_c,
  output logic [OPW-1:0]  o_d,
  output logic [OPW-1:0]  o_e,
  output logic [OPW-1:0]  o_f,
  output logic [OPW-1:0]  o_g,
  output logic [OPW-1:0]  o_h,
  output logic            o_issue,
  input  logic [RESW-1:0] i_dp_out,
  output logic [RESW-1:0] o_res,
  output logic [IW-1:0]   o_res_idx,
  output logic            o_res_vld,
  output logic            o_busy,
  output logic            o_done
);

  localparam logic [IW:0] DEPTH_N = (IW+1)'(DEPTH);

  state_e          state_q, state_d;
  logic [VECW-1:0] slot_q [DEPTH];
  logic [IW:0]     num_q, n_clamp;
  logic [IW-1:0]   idx_q, idx_nxt;
  vec_ops_t        ops_q;
  logic            issue_q, last_issue;
  logic [VECW-1:0] first_word;
  logic            trk_tail_vld, trk_empty;
  logic [IW-1:0]   trk_tail_idx;
  logic [RESW-1:0] res_q;
  logic [IW-1:0]   res_idx_q;
  logic            res_vld_q;

  assign n_clamp    = (i_num > DEPTH_N) ? DEPTH_N : i_num;
  assign idx_nxt    = idx_q + 1'b1;
  assign last_issue = ({1'b0, idx_q} == num_q - 1'b1);
  // A write to slot 0 in the start cycle must be seen by the first issue.
  assign first_word = (i_wr_en && i_wr_addr == '0) ? i_wr_data : slot_q[0];

  // NOTE: next-state gets its default before the case, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_start) state_d = (n_clamp == '0) ? DONE : ISSUE;
      ISSUE:   if (last_issue) state_d = DRAIN;
      DRAIN:   if (trk_empty && res_vld_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the slot file is reset because a run after reset must read zeros.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else if (state_q == IDLE && i_wr_en) begin
      slot_q[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      issue_q <= 1'b0;
      ops_q   <= '0;
      idx_q   <= '0;
      num_q   <= '0;
    end else begin
      issue_q <= 1'b0;
      ops_q   <= '0;
      if (state_q == IDLE && i_start && n_clamp != '0) begin
        issue_q <= 1'b1;
        ops_q   <= unpack_vec(first_word);
        idx_q   <= '0;
        num_q   <= n_clamp;
      end else if (state_q == ISSUE && !last_issue) begin
        issue_q <= 1'b1;
        ops_q   <= unpack_vec(slot_q[idx_nxt]);
        idx_q   <= idx_nxt;
      end
    end
  end

  dot_vec_tracker #(
    .LAT (LAT),
    .IW  (IW)
  ) u_tracker (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_vld      (issue_q),
    .i_idx      (idx_q),
    .o_tail_vld (trk_tail_vld),
    .o_tail_idx (trk_tail_idx),
    .o_empty    (trk_empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      res_q     <= '0;
      res_idx_q <= '0;
      res_vld_q <= 1'b0;
    end else begin
      res_vld_q <= trk_tail_vld;
      if (trk_tail_vld) begin
        res_q     <= i_dp_out;
        res_idx_q <= trk_tail_idx;
      end
    end
  end

  assign o_a       = ops_q.a;
  assign o_b       = ops_q.b;
  assign o_c       = ops_q.c;
  assign o_d       = ops_q.d;
  assign o_e       = ops_q.e;
  assign o_f       = ops_q.f;
  assign o_g       = ops_q.g;
  assign o_h       = ops_q.h;
  assign o_issue   = issue_q;
  assign o_res     = res_q;
  assign o_res_idx = res_idx_q;
  assign o_res_vld = res_vld_q;
  assign o_busy    = (state_q == ISSUE) || (state_q == DRAIN);
  assign o_done    = (state_q == DONE);

endmodule

// File: tb/tb_dot_vec_streamer.sv
// Self-checking bench for dot_vec_streamer; a LAT-stage dot-product model
// sits downstream and expectations come from a slot-array reference model.
module tb_dot_vec_streamer;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam int IW    = 2;

  logic          clk;
  logic          i_rst;
  logic          i_wr_en;
  logic [IW-1:0] i_wr_addr;
  logic [31:0]   i_wr_data;
  logic          i_start;
  logic [IW:0]   i_num;
  logic [3:0]    o_a, o_b, o_c, o_d, o_e, o_f, o_g, o_h;
  logic          o_issue;
  logic [9:0]    i_dp_out;
  logic [9:0]    o_res;
  logic [IW-1:0] o_res_idx;
  logic          o_res_vld;
  logic          o_busy;
  logic          o_done;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] slot_mem [DEPTH];
  logic [9:0]  exp_res_hold;
  logic [9:0]  dp_pipe [LAT];

  dot_vec_streamer #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_start   (i_start),
    .i_num     (i_num),
    .o_a       (o_a),
    .o_b       (o_b),
    .o_c       (o_c),
    .o_d       (o_d),
    .o_e       (o_e),
    .o_f       (o_f),
    .o_g       (o_g),
    .o_h       (o_h),
    .o_issue   (o_issue),
    .i_dp_out  (i_dp_out),
    .o_res     (o_res),
    .o_res_idx (o_res_idx),
    .o_res_vld (o_res_vld),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] dot(input logic [31:0] w);
    int s;
    s = 0;
    for (int p = 0; p < 4; p++) s += int'(w[31-8*p -: 4]) * int'(w[27-8*p -: 4]);
    return 10'(s);
  endfunction

  // Downstream dot-product unit: result appears LAT cycles after its operands.
  always @(posedge clk) begin
    dp_pipe[0] <= dot({o_a, o_b, o_c, o_d, o_e, o_f, o_g, o_h});
    for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign i_dp_out = dp_pipe[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input logic [IW-1:0] a, input logic [31:0] d);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
    tick();
    i_wr_en = 1'b0;
    slot_mem[a] = d;
  endtask

  // Starts a run and compares every output on every cycle until back in idle.
  task automatic drive_stream(input string name, input int num_in, input int inject_j,
                              input bit wr_first, input logic [IW-1:0] waddr,
                              input logic [31:0] wdata);
    int          n;
    logic        e_issue, e_vld, e_busy, e_done;
    logic [31:0] e_ops, g_ops;
    logic [IW-1:0] e_idx;
    if (wr_first) begin
      i_wr_en = 1'b1; i_wr_addr = waddr; i_wr_data = wdata;
      slot_mem[waddr] = wdata;
    end
    i_start = 1'b1;
    i_num   = num_in[IW:0];
    n = (num_in > DEPTH) ? DEPTH : num_in;
    tick();
    i_start = 1'b0; i_wr_en = 1'b0; i_num = '0;
    for (int j = 0; j <= n + LAT + 2; j++) begin
      e_issue = (j < n);
      e_ops   = e_issue ? slot_mem[j] : 32'h0;
      e_vld   = (j >= LAT + 1) && (j <= n + LAT);
      e_idx   = '0;
      if (e_vld) begin
        exp_res_hold = dot(slot_mem[j-LAT-1]);
        e_idx = IW'(j - LAT - 1);
      end
      e_busy = (n > 0) && (j <= n + LAT);
      e_done = (n > 0) ? (j == n + LAT + 1) : (j == 0);
      g_ops  = {o_a, o_b, o_c, o_d, o_e, o_f, o_g, o_h};
      n_cmp++;
      if (o_issue !== e_issue) begin
        n_err++; $display("FAIL %s j=%0d o_issue got %0b exp %0b", name, j, o_issue, e_issue);
      end
      n_cmp++;
      if (g_ops !== e_ops) begin
        n_err++; $display("FAIL %s j=%0d operands got %h exp %h", name, j, g_ops, e_ops);
      end
      n_cmp++;
      if (o_res_vld !== e_vld) begin
        n_err++; $display("FAIL %s j=%0d o_res_vld got %0b exp %0b", name, j, o_res_vld, e_vld);
      end
      n_cmp++;
      if (o_res !== exp_res_hold) begin
        n_err++; $display("FAIL %s j=%0d o_res got %0d exp %0d", name, j, o_res, exp_res_hold);
      end
      if (e_vld) begin
        n_cmp++;
        if (o_res_idx !== e_idx) begin
          n_err++; $display("FAIL %s j=%0d o_res_idx got %0d exp %0d", name, j, o_res_idx, e_idx);
        end
      end
      n_cmp++;
      if (o_busy !== e_busy) begin
        n_err++; $display("FAIL %s j=%0d o_busy got %0b exp %0b", name, j, o_busy, e_busy);
      end
      n_cmp++;
      if (o_done !== e_done) begin
        n_err++; $display("FAIL %s j=%0d o_done got %0b exp %0b", name, j, o_done, e_done);
      end
      if (j == inject_j) begin
        i_start = 1'b1; i_num = 3'd4;
        i_wr_en = 1'b1; i_wr_addr = 2'd2; i_wr_data = 32'hDEAD_BEEF;
      end
      tick();
      i_start = 1'b0; i_wr_en = 1'b0; i_num = '0;
    end
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++;
    if ({o_a, o_b, o_c, o_d, o_e, o_f, o_g, o_h} !== 32'h0) begin
      n_err++; $display("FAIL %s operands got %h exp 0", name, {o_a, o_b, o_c, o_d, o_e, o_f, o_g, o_h});
    end
    n_cmp++;
    if ({o_issue, o_res_vld, o_busy, o_done} !== 4'b0) begin
      n_err++; $display("FAIL %s flags issue/vld/busy/done got %b exp 0000", name,
                        {o_issue, o_res_vld, o_busy, o_done});
    end
    n_cmp++;
    if (o_res !== 10'd0) begin
      n_err++; $display("FAIL %s o_res got %0d exp 0", name, o_res);
    end
    n_cmp++;
    if (o_res_idx !== '0) begin
      n_err++; $display("FAIL %s o_res_idx got %0d exp 0", name, o_res_idx);
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    check_all_zero("reset_hold");
    i_rst = 1'b0;
    tick();
    check_all_zero("reset_release");
  endtask

  task automatic test_single();
    write_slot(2'd0, 32'h1111_1111);
    drive_stream("single", 1, -1, 1'b0, '0, '0);
  endtask

  task automatic test_four();
    write_slot(2'd0, 32'h1111_1111);
    write_slot(2'd1, 32'hFFFF_FFFF);
    write_slot(2'd2, 32'h2345_6789);
    write_slot(2'd3, 32'h0000_0000);
    drive_stream("four", 4, -1, 1'b0, '0, '0);
  endtask

  task automatic test_zero_and_clamp();
    drive_stream("zero", 0, -1, 1'b0, '0, '0);
    drive_stream("clamp7", 7, -1, 1'b0, '0, '0);
  endtask

  task automatic test_ignore_during_drain();
    drive_stream("ignore_drain", 4, 4 + 1, 1'b0, '0, '0);
    drive_stream("after_ignore", 4, -1, 1'b0, '0, '0);
  endtask

  task automatic test_same_cycle_write();
    drive_stream("same_cycle_wr", 1, -1, 1'b1, 2'd0, 32'h2222_2222);
  endtask

  task automatic test_reset_mid();
    i_start = 1'b1; i_num = 3'd4;
    tick();
    i_start = 1'b0; i_num = '0;
    for (int j = 0; j < 2; j++) begin
      n_cmp++;
      if (o_issue !== 1'b1) begin
        n_err++; $display("FAIL mid_reset pre j=%0d o_issue got %0b exp 1", j, o_issue);
      end
      if (j == 0) tick();
    end
    #2 i_rst = 1'b1;
    #1 check_all_zero("mid_reset_async");
    tick();
    i_rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) slot_mem[i] = '0;
    exp_res_hold = '0;
    for (int j = 0; j < 8; j++) begin
      tick();
      check_all_zero("mid_reset_after");
    end
    drive_stream("post_reset_run", 4, -1, 1'b0, '0, '0);
  endtask

  task automatic test_random();
    int num, inj, n;
    for (int r = 0; r < 12; r++) begin
      for (int s = 0; s < DEPTH; s++)
        if ($urandom_range(1, 0) == 1) write_slot(IW'(s), $urandom);
      num = $urandom_range(7, 0);
      n   = (num > DEPTH) ? DEPTH : num;
      inj = (n > 0) ? int'($urandom_range(n + LAT, 0)) : -1;
      drive_stream("random", num, inj, 1'($urandom_range(1, 0)),
                   IW'($urandom_range(DEPTH - 1, 0)), $urandom);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    i_start = 1'b0; i_num = '0;
    exp_res_hold = '0;
    for (int i = 0; i < DEPTH; i++) slot_mem[i] = '0;
    test_reset();
    test_single();
    test_four();
    test_zero_and_clamp();
    test_ignore_during_drain();
    test_same_cycle_write();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
